// File: rtl/fpu_issue_sequencer_pkg.sv
// Shared FPU issue constants: unit selects, sequencer state encodings, flag bit indices
// and small decode helpers used by the sequencer and the FPU decode stage.
package fpu_issue_sequencer_pkg;

  localparam logic [4:0] SEL_ADD    = 5'd4;
  localparam logic [4:0] SEL_SUB    = 5'd5;
  localparam logic [4:0] SEL_MUL    = 5'd6;
  localparam logic [4:0] SEL_MIN    = 5'd7;
  localparam logic [4:0] SEL_MAX    = 5'd8;
  localparam logic [4:0] SEL_FEQ    = 5'd9;
  localparam logic [4:0] SEL_FLT    = 5'd10;
  localparam logic [4:0] SEL_FLE    = 5'd11;
  localparam logic [4:0] SEL_MV_XW  = 5'd12;
  localparam logic [4:0] SEL_MV_WX  = 5'd13;
  localparam logic [4:0] SEL_CVT_SW = 5'd14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Counter preload is latency minus one; latency is clamped to 1..15.
  function automatic logic [3:0] lat_load(input int lat);
    if (lat <= 1)       return 4'd0;
    else if (lat >= 15) return 4'd14;
    else                return 4'(lat - 1);
  endfunction

  function automatic logic sel_legal(input logic [4:0] sel);
    case (sel)
      SEL_ADD, SEL_SUB, SEL_MUL, SEL_MIN, SEL_MAX, SEL_FEQ, SEL_FLT,
      SEL_FLE, SEL_MV_XW, SEL_MV_WX, SEL_CVT_SW: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  function automatic logic sel_to_int(input logic [4:0] sel);
    case (sel)
      SEL_FEQ, SEL_FLT, SEL_FLE, SEL_MV_XW: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_sequencer_lat_counter.sv
// 4-bit latency down-counter: load, decrement while non-zero, zero detect.
module fpu_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= 4'd0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/fpu_issue_sequencer.sv
// FP issue sequencer: issues one op, times its latency, holds the result for writeback.
// Optional sticky exception flags when FPU_SEQ_FFLAGS_EN is defined.
module fpu_issue_sequencer
  import fpu_issue_sequencer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_MISC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_sel,
  input  logic [4:0]      in_rd,
  output logic            stall,
  output logic            fpu_start,
  output logic [4:0]      fpu_sel,
  input  logic [XLEN-1:0] fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_to_int,
  output logic            illegal_op
`ifdef FPU_SEQ_FFLAGS_EN
  ,
  input  logic            fflags_clr,
  output logic [4:0]      fflags
`endif
);

  logic [1:0] state;
  logic       accept;
  logic       legal;
  logic       capture;
  logic       cnt_zero;
  logic [3:0] lat_init;

  assign in_ready = (state == ST_IDLE);
  assign wb_valid = (state == ST_DONE);
  assign stall    = in_valid & ~in_ready;
  assign accept   = in_valid & in_ready;
  assign legal    = sel_legal(in_sel);
  assign capture  = (state == ST_EXEC) & cnt_zero;

  always_comb begin
    case (in_sel)
      SEL_ADD, SEL_SUB: lat_init = lat_load(LAT_ADD);
      SEL_MUL:          lat_init = lat_load(LAT_MUL);
      default:          lat_init = lat_load(LAT_MISC);
    endcase
  end

  fpu_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (accept & legal),
    .load_val (lat_init),
    .dec      (state == ST_EXEC),
    .zero     (cnt_zero)
  );

  // Illegal selects skip EXEC entirely and report a zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fpu_start  <= 1'b0;
      fpu_sel    <= 5'd0;
      wb_data    <= '0;
      wb_rd      <= 5'd0;
      wb_to_int  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            wb_rd      <= in_rd;
            wb_to_int  <= sel_to_int(in_sel);
            illegal_op <= ~legal;
            if (legal) begin
              fpu_sel   <= in_sel;
              fpu_start <= 1'b1;
              state     <= ST_EXEC;
            end else begin
              wb_data <= '0;
              state   <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          if (capture) begin
            wb_data <= fpu_result;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FPU_SEQ_FFLAGS_EN
  // Clear takes priority over a capture in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || fflags_clr)   fflags <= 5'd0;
    else if (capture)        fflags <= fflags | fpu_flags;
    else if (accept && !legal) fflags[FLAG_NV] <= 1'b1;
  end
`else
  logic unused_flags;
  assign unused_flags = ^fpu_flags;
`endif

endmodule
